fp_round_pack: RTL
==================

FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  upstream offers an operand this cycle.
REQ-004 in_ready  output  1  block accepts the operand this cycle; transfer when in_valid&&in_ready.
REQ-005 in_sign  input  1  product sign.
REQ-006 in_exp  input  10  signed two's-complement biased exponent sum, before normalization adjust.
REQ-007 in_mant  input  49  normalized mantissa product from normalizer; in_mant[48] is the leading one.
REQ-008 in_shamt  input  9  normalizer shift amount, unsigned.
REQ-009 in_special  input  2  class: 00 normal, 01 zero, 10 infinity, 11 NaN.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts result; transfer when out_valid&&out_ready.
REQ-012 out_result  output  32  IEEE-754 single-precision packed result.
REQ-013 out_flags  output  3  per-result {overflow, underflow, inexact}.
REQ-014 flag_clr  input  1  clears sticky flags.
REQ-015 sticky_flags  output  3  OR-accumulated {overflow, underflow, inexact} of all transferred results.

Function
REQ-016 Two-register pipeline (S1, S2); latency exactly 2 cycles from input transfer to out_valid with no backpressure.
REQ-017 in_ready = !S1_valid || S1 advances this cycle; S1 advances when !S2_valid || out_ready; throughput one result per cycle.
REQ-018 S1 registers: sign, class, E = sext(in_exp) - zext(in_shamt) in 11-bit signed, fraction = in_mant[47:25], guard = in_mant[24], round = in_mant[23], sticky = |in_mant[22:0].
REQ-019 S1 rounding decision, round-to-nearest-even: increment = guard && (round || sticky || fraction[0]); inexact = guard||round||sticky.
REQ-020 S2 applies increment on 24-bit {1,fraction}; carry-out yields fraction 0 and E+1.
REQ-021 Overflow: final E >= 255 -> {sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
REQ-022 Underflow: final E <= 0 -> signed zero {sign, 31'h0}, underflow=1, inexact=1; no subnormal output.
REQ-023 Normal: {sign, E[7:0], fraction}, flags {0,0,inexact}.
REQ-024 Class zero -> {sign,31'h0}; infinity -> {sign,8'hFF,23'h0}; NaN -> 32'h7FC00000; all flags 0; mantissa/exponent ignored.
REQ-025 out_result/out_flags held stable while out_valid && !out_ready.
REQ-026 Sticky update on output transfer: sticky_flags |= out_flags; flag_clr same cycle as transfer: clear wins, transferred flags discarded; flag_clr without transfer: clear to 0.
REQ-027 Results emerge in acceptance order; none dropped or duplicated under any out_ready pattern.

Reset
REQ-028 rst clears S1_valid, S2_valid, out_valid, sticky_flags to 0; out_result=0, out_flags=0.
REQ-029 in_ready=1 in the first cycle after rst deasserts.
REQ-030 rst mid-operation discards all in-flight operands; no result for them is ever presented.

Structure
REQ-031 Shared package fp_pkg holds BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, and the in_special class encodings.
REQ-032 One sub-module rne_incr: combinational 24-bit round-to-nearest-even incrementer with carry-out; all state in fp_round_pack.

Verification
REQ-033 in_exp=127, shamt=0, mant={1,48'h0} -> out_result=32'h3F800000, flags 000, out_valid 2 cycles after transfer.
REQ-034 in_exp=127, fraction=23'h000001, guard=1, round=0, sticky=0 -> 32'h3F800002, inexact=1; fraction=23'h000000, same GRS -> 32'h3F800000, inexact=1.
REQ-035 in_exp=127, fraction=23'h7FFFFF, guard=1 -> 32'h40000000 (carry); in_exp=254 same mantissa -> 32'h7F800000, flags 101, sticky_flags=101.
REQ-036 in_exp=3, shamt=5 -> 32'h00000000 with in_sign=0, flags 011; class NaN -> 32'h7FC00000, flags 000.
REQ-037 out_ready=0 for 4 cycles while 4 operands offered -> exactly 2 accepted, in_ready low after, then out_ready=1 -> all 4 delivered in order.
REQ-038 rst asserted with S1 and S2 full -> next cycle out_valid=0, sticky_flags=0, in_ready=1; no stale result appears.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and stage-1 record for the FP multiplier round/pack stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // in_special operand classes
  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [1:0] CLS_NAN    = 2'b11;

  // Stage-1 contents: exponent already adjusted by the normalizer shift,
  // rounding decision already made, only the increment is left for stage 2.
  typedef struct packed {
    logic        sign;
    logic [1:0]  cls;
    logic [10:0] exp;      // two's complement
    logic [22:0] frac;
    logic        incr;
    logic        inexact;
  } s1_t;

endpackage

// File: rtl/rne_incr.sv
// Round-to-nearest-even incrementer: adds the precomputed round-up bit to {1,fraction}.
// Latency: combinational.
// Backpressure: none (pure logic).
module rne_incr (
  input  logic [23:0] mant_in,
  input  logic        incr,
  output logic [23:0] mant_out,
  output logic        carry
);

  // Single add; the carry-out signals that the mantissa wrapped to 2.0
  always_comb begin
    {carry, mant_out} = {1'b0, mant_in} + {24'd0, incr};
  end

endmodule

// File: rtl/fp_round_pack.sv
// Rounds a normalized product to IEEE single precision and packs it, with sticky flags.
// Latency: 2 cycles from input transfer to out_valid; one result per cycle.
// Backpressure: valid/ready; output register holds while !out_ready, S1 stalls behind it.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [48:0] in_mant,
  input  logic [8:0]  in_shamt,
  input  logic [1:0]  in_special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  input  logic        flag_clr,
  output logic [2:0]  sticky_flags
);

  localparam logic signed [11:0] EXP_MAX_S = 12'(EXP_MAX);

  s1_t                s1_q, s1_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s2_vld_q, s2_vld_d;
  logic [31:0]        res_q, res_d;
  logic [2:0]         flg_q, flg_d;
  logic [2:0]         sticky_q, sticky_d;
  logic               s2_adv;
  logic               g_bit, r_bit, s_bit;
  logic [23:0]        rnd_mant;
  logic               rnd_carry;
  logic signed [11:0] exp_fin;
  logic [22:0]        frac_fin;
  logic [31:0]        pk_res;
  logic [2:0]         pk_flg;
  logic               lead_unused;

  // The leading one is implied by the packed format and never stored
  assign lead_unused = in_mant[48];

  // Stage 1: handshake and capture with exponent adjust and RNE decision
  always_comb begin
    s2_adv   = !s2_vld_q || out_ready;
    in_ready = !s1_vld_q || s2_adv;
    s1_vld_d = in_ready ? in_valid : s1_vld_q;
    g_bit    = in_mant[24];
    r_bit    = in_mant[23];
    s_bit    = |in_mant[22:0];
    s1_d     = s1_q;
    if (in_valid && in_ready) begin
      s1_d.sign    = in_sign;
      s1_d.cls     = in_special;
      s1_d.exp     = {in_exp[9], in_exp} - {2'b00, in_shamt};
      s1_d.frac    = in_mant[47:25];
      s1_d.incr    = g_bit && (r_bit || s_bit || in_mant[25]);
      s1_d.inexact = g_bit || r_bit || s_bit;
    end
  end

  rne_incr u_rne_incr (
    .mant_in  ({1'b1, s1_q.frac}),
    .incr     (s1_q.incr),
    .mant_out (rnd_mant),
    .carry    (rnd_carry)
  );

  // Stage 2 datapath: renormalize after carry, then classify and pack
  always_comb begin
    exp_fin  = $signed({s1_q.exp[10], s1_q.exp}) + $signed({11'd0, rnd_carry});
    frac_fin = rnd_carry ? rnd_mant[23:1] : rnd_mant[22:0];
    pk_res   = '0;
    pk_flg   = '0;
    case (s1_q.cls)
      CLS_ZERO: pk_res = {s1_q.sign, 31'h0};
      CLS_INF:  pk_res = {s1_q.sign, 8'hFF, 23'h0};
      CLS_NAN:  pk_res = QNAN;
      default: begin
        if (exp_fin >= EXP_MAX_S) begin
          pk_res = {s1_q.sign, 8'hFF, 23'h0};
          pk_flg = 3'b101;
        end else if (exp_fin <= 12'sd0) begin
          pk_res = {s1_q.sign, 31'h0};
          pk_flg = 3'b011;
        end else begin
          pk_res = {s1_q.sign, exp_fin[7:0], frac_fin};
          pk_flg = {2'b00, s1_q.inexact};
        end
      end
    endcase
  end

  // Stage 2 handshake, output hold, and sticky accumulation (clear wins)
  always_comb begin
    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    res_d    = res_q;
    flg_d    = flg_q;
    if (s2_adv && s1_vld_q) begin
      res_d = pk_res;
      flg_d = pk_flg;
    end
    sticky_d = sticky_q;
    if (flag_clr) begin
      sticky_d = 3'b000;
    end else if (s2_vld_q && out_ready) begin
      sticky_d = sticky_q | flg_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
      sticky_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid    = s2_vld_q;
  assign out_result   = res_q;
  assign out_flags    = flg_q;
  assign sticky_flags = sticky_q;

endmodule
